alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single registered 8-bit ALU between two requesters (port 0, port 1).
//  Arbitrates round-robin, drives ALU A/B/CTR, tracks the fixed ALU pipeline latency
//  and routes each ALU result back to the requester that issued it.
//  Allows one issue per cycle; per-port outstanding limit; flags reserved opcodes.
// PARAMETERS
//  W        8  datapath width (A, B, result)
//  ALU_LAT  2  cycles from issue on alu_a/b/ctr to valid result on alu_o
//  MAX_OUT  2  max in-flight ops per port (1..ALU_LAT)
// PORTS
//  ck          in   1  clock, all state updates on posedge
//  rst         in   1  synchronous reset, active-high
//  req0_valid  in   1  port 0 has an op
//  req0_ready  out  1  port 0 op accepted this cycle (valid & ready = issue)
//  req0_a/b    in   W  operands, port 0
//  req0_op     in   4  ALU opcode, port 0
//  rsp0_valid  out  1  one-cycle pulse: result for port 0
//  rsp0_data   out  W  result, port 0
//  rsp0_err    out  1  with rsp0_valid: op was reserved (4'b0010..4'b0111)
//  req1_* / rsp1_*  as port 0, for port 1
//  alu_a/b     out  W  to ALU A/B
//  alu_ctr     out  4  to ALU CTR
//  alu_o       in   W  from ALU output
// BEHAVIOUR
//  - Reset: rsp*_valid=0, rsp*_data=0, rsp*_err=0, priority=port 0, tag pipe empty,
//    outstanding counters=0. In-flight ops at reset are dropped, never responded.
//  - Eligible(i) = reqi_valid & (out_cnt_i < MAX_OUT). Grant is combinational:
//    one eligible -> it; both eligible -> priority port. reqi_ready = grant_i.
//  - Priority: after a grant to port i, priority moves to the other port; with no
//    grant, priority holds. Neither port waits more than one grant when both eligible.
//  - Issue cycle: alu_a/b/ctr = granted port's a/b/op. No grant: alu_a=alu_b=0,
//    alu_ctr=4'b0000 (bubble; its result is discarded).
//  - Tag pipe: ALU_LAT-deep shift register of {valid, port, reserved}; stage 0 loaded
//    at issue edge. When the last stage is valid, alu_o is the result of that op.
//  - Response registered: on edge where last stage valid, rspP_valid<=1,
//    rspP_data<=(reserved ? 0 : alu_o), rspP_err<=reserved; other port's valid<=0.
//    Total: issue in cycle N -> rsp_valid high in cycle N+ALU_LAT+1.
//    rsp_data/err hold last value when valid=0. No response backpressure.
//  - out_cnt_i: +1 on issue to i, -1 when response for i registered, unchanged if both
//    same edge. Width ceil(log2(MAX_OUT+1)); never exceeds MAX_OUT, never underflows.
//  - Results return strictly in issue order; back-to-back issues give back-to-back rsp.
//  - Arithmetic is the ALU's: modulo 2^W, no carry/borrow out; arbiter does not compute.
// TESTING
//  1. Port0 op=4'b0000 a=8'h12 b=8'h34 issued cycle 1 -> rsp0_valid cycle 4, data=8'h46, err=0.
//  2. Both ports valid every cycle from reset -> grants alternate 0,1,0,1; op=4'b0001
//     a=8'h05 b=8'h07 -> data=8'hFE; each port limited to MAX_OUT in flight.
//  3. Port1 op=4'b0100 a=8'hFF b=8'h01 -> rsp1_valid, data=8'h00, err=1.
//  4. Port0 alone, 3 back-to-back ops, MAX_OUT=2 -> third ready held low until first
//     rsp; rsp order matches issue order, no bubble beyond one stall.
//  5. rst asserted with 2 ops in flight -> no rsp_valid ever produced for them;
//     counters 0, next grant goes to port 0.
//  6. Random ops on both ports vs reference model of ALU ops (add,sub,and,or,xor,not,
//     shr,shl,ror,rol) for 1000 cycles -> every result matches, none lost or duplicated.

Source files
------------

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Requester-side handshake bundle for one alu_arbiter port.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int W = 8
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [3:0]   req_op;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one pipelined ALU between two requesters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int W       = 8,
  parameter int ALU_LAT = 2,
  parameter int MAX_OUT = 2
) (
  input  logic          ck,
  input  logic          rst,
  alu_arbiter_if.slave  port0,
  alu_arbiter_if.slave  port1,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_ctr,
  input  logic [W-1:0]  alu_o
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_OUT);

  logic [CW-1:0]      cnt0, cnt1;
  logic               prio;
  logic               elig0, elig1, grant0, grant1;
  logic               issue_res;
  logic [ALU_LAT-1:0] tag_v, tag_p, tag_r;
  logic               last_v, last_p, last_r;
  logic               done0, done1;
  logic               rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [W-1:0]       rsp0_data, rsp1_data;

  assign elig0  = port0.req_valid && (cnt0 < C_MAX);
  assign elig1  = port1.req_valid && (cnt1 < C_MAX);
  // prio==0 favours port 0 on a tie
  assign grant0 = elig0 && (!elig1 || !prio);
  assign grant1 = elig1 && (!elig0 || prio);

  assign port0.req_ready = grant0;
  assign port1.req_ready = grant1;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 4'b0000;
    if (grant0) begin
      alu_a   = port0.req_a;
      alu_b   = port0.req_b;
      alu_ctr = port0.req_op;
    end else if (grant1) begin
      alu_a   = port1.req_a;
      alu_b   = port1.req_b;
      alu_ctr = port1.req_op;
    end
  end

  assign issue_res = alu_ctr inside {[4'b0010:4'b0111]};

  assign last_v = tag_v[ALU_LAT-1];
  assign last_p = tag_p[ALU_LAT-1];
  assign last_r = tag_r[ALU_LAT-1];
  assign done0  = last_v && !last_p;
  assign done1  = last_v && last_p;

  always_ff @(posedge ck) begin
    if (rst) begin
      tag_v      <= '0;
      tag_p      <= '0;
      tag_r      <= '0;
      cnt0       <= '0;
      cnt1       <= '0;
      prio       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
    end else begin
      tag_v[0] <= grant0 || grant1;
      tag_p[0] <= grant1;
      tag_r[0] <= issue_res;
      for (int s = 1; s < ALU_LAT; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_p[s] <= tag_p[s-1];
        tag_r[s] <= tag_r[s-1];
      end

      rsp0_valid <= done0;
      rsp1_valid <= done1;
      if (done0) begin
        rsp0_data <= last_r ? '0 : alu_o;
        rsp0_err  <= last_r;
      end
      if (done1) begin
        rsp1_data <= last_r ? '0 : alu_o;
        rsp1_err  <= last_r;
      end

      // issue and retire on the same edge cancel out
      cnt0 <= cnt0 + CW'(grant0) - CW'(done0);
      cnt1 <= cnt1 + CW'(grant1) - CW'(done1);

      if (grant0)      prio <= 1'b1;
      else if (grant1) prio <= 1'b0;
    end
  end

  assign port0.rsp_valid = rsp0_valid;
  assign port0.rsp_data  = rsp0_data;
  assign port0.rsp_err   = rsp0_err;
  assign port1.rsp_valid = rsp1_valid;
  assign port1.rsp_data  = rsp1_data;
  assign port1.rsp_err   = rsp1_err;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with an external ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int W       = 8;
  localparam int ALU_LAT = 2;
  localparam int MAX_OUT = 2;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] alu_a, alu_b, alu_o;
  logic [3:0]   alu_ctr;
  logic [W-1:0] s1, s2;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  alu_arbiter_if #(.W(W)) p0 ();
  alu_arbiter_if #(.W(W)) p1 ();

  alu_arbiter #(.W(W), .ALU_LAT(ALU_LAT), .MAX_OUT(MAX_OUT)) dut (
    .ck      (ck),
    .rst     (rst),
    .port0   (p0),
    .port1   (p1),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ctr (alu_ctr),
    .alu_o   (alu_o)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd11:   return ~a;
      4'd12:   return a >> 1;
      4'd13:   return a << 1;
      4'd14:   return {a[0], a[7:1]};
      4'd15:   return {a[6:0], a[7]};
      default: return a ^ b ^ 8'h5A;
    endcase
  endfunction

  // Two-stage registered ALU: result appears ALU_LAT cycles after issue
  always @(posedge ck) begin
    s1 <= alu_fn(alu_a, alu_b, alu_ctr);
    s2 <= s1;
  end
  assign alu_o = s2;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: per-port queues of expected responses, tie-break port
  typedef struct {
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tie_port = 0;

  function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input int now);
    exp_t e;
    e.err  = (op >= 4'd2) && (op <= 4'd7);
    e.data = e.err ? 8'h00 : alu_fn(a, b, op);
    e.due  = now + ALU_LAT + 1;
    return e;
  endfunction

  always @(negedge ck) begin
    logic ev, el0, el1, g0, g1;
    if (rst) begin
      q0.delete();
      q1.delete();
      tie_port = 0;
    end else begin
      ev = (q0.size() > 0) && (q0[0].due == cyc);
      check_value("rsp0_valid", 32'(p0.rsp_valid), 32'(ev));
      if (ev) begin
        check_value("rsp0_data", 32'(p0.rsp_data), 32'(q0[0].data));
        check_value("rsp0_err", 32'(p0.rsp_err), 32'(q0[0].err));
        void'(q0.pop_front());
      end
      ev = (q1.size() > 0) && (q1[0].due == cyc);
      check_value("rsp1_valid", 32'(p1.rsp_valid), 32'(ev));
      if (ev) begin
        check_value("rsp1_data", 32'(p1.rsp_data), 32'(q1[0].data));
        check_value("rsp1_err", 32'(p1.rsp_err), 32'(q1[0].err));
        void'(q1.pop_front());
      end

      el0 = p0.req_valid && (q0.size() < MAX_OUT);
      el1 = p1.req_valid && (q1.size() < MAX_OUT);
      g0  = el0 && (!el1 || tie_port == 0);
      g1  = el1 && (!el0 || tie_port == 1);
      check_value("ready0", 32'(p0.req_ready), 32'(g0));
      check_value("ready1", 32'(p1.req_ready), 32'(g1));
      if (g0) begin
        q0.push_back(make_exp(p0.req_a, p0.req_b, p0.req_op, cyc));
        tie_port = 1;
      end else if (g1) begin
        q1.push_back(make_exp(p1.req_a, p1.req_b, p1.req_op, cyc));
        tie_port = 0;
      end
    end
  end

  task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] o0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] o1);
    @(posedge ck);
    #1;
    p0.req_valid = v0; p0.req_a = a0; p0.req_b = b0; p0.req_op = o0;
    p1.req_valid = v1; p1.req_a = a1; p1.req_b = b1; p1.req_op = o1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
  endtask

  initial begin
    p0.req_valid = 1'b0; p0.req_a = '0; p0.req_b = '0; p0.req_op = '0;
    p1.req_valid = 1'b0; p1.req_a = '0; p1.req_b = '0; p1.req_op = '0;
    rst = 1'b1;
    repeat (3) @(posedge ck);
    #1 rst = 1'b0;
    @(negedge ck);
    check_value("reset_rsp0_valid", 32'(p0.rsp_valid), 32'd0);
    check_value("reset_rsp0_data", 32'(p0.rsp_data), 32'd0);
    check_value("reset_rsp0_err", 32'(p0.rsp_err), 32'd0);
    check_value("reset_rsp1_valid", 32'(p1.rsp_valid), 32'd0);
    check_value("reset_rsp1_data", 32'(p1.rsp_data), 32'd0);
    check_value("reset_rsp1_err", 32'(p1.rsp_err), 32'd0);

    // single add on port 0
    drive(1'b1, 8'h12, 8'h34, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    idle(5);
    check_value("t1_data", 32'(p0.rsp_data), 32'h46);
    check_value("t1_err", 32'(p0.rsp_err), 32'd0);

    // both ports contend with subtraction
    repeat (8) drive(1'b1, 8'h05, 8'h07, 4'h1, 1'b1, 8'h05, 8'h07, 4'h1);
    idle(6);
    check_value("t2_data0", 32'(p0.rsp_data), 32'hFE);
    check_value("t2_data1", 32'(p1.rsp_data), 32'hFE);

    // reserved opcode on port 1
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b1, 8'hFF, 8'h01, 4'h4);
    idle(5);
    check_value("t3_data", 32'(p1.rsp_data), 32'h00);
    check_value("t3_err", 32'(p1.rsp_err), 32'd1);

    // port 0 alone, back-to-back, hits the outstanding limit
    drive(1'b1, 8'h10, 8'h01, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b1, 8'h20, 8'h02, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b1, 8'h30, 8'h03, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    @(negedge ck);
    check_value("t4_stall", 32'(p0.req_ready), 32'd0);
    drive(1'b1, 8'h30, 8'h03, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    @(negedge ck);
    check_value("t4_resume", 32'(p0.req_ready), 32'd1);
    idle(6);
    check_value("t4_last_data", 32'(p0.rsp_data), 32'h33);

    // reset with two ops in flight; tie must go to port 0 afterwards
    drive(1'b1, 8'h01, 8'h01, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b1, 8'h02, 8'h02, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    drive(1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 8'h00, 4'h0);
    rst = 1'b1;
    @(posedge ck);
    #1 rst = 1'b0;
    check_value("t5_data_cleared", 32'(p0.rsp_data), 32'd0);
    idle(6);
    drive(1'b1, 8'h09, 8'h01, 4'h0, 1'b1, 8'h09, 8'h02, 4'h0);
    @(negedge ck);
    check_value("t5_grant0", 32'(p0.req_ready), 32'd1);
    check_value("t5_grant1", 32'(p1.req_ready), 32'd0);
    idle(6);

    // randomized traffic on both ports
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom),
            $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 4'($urandom));
    end
    idle(8);
    check_value("drain", 32'(q0.size() + q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
